// File: rtl/timers_pkg.sv
// Shared definitions for the timer input conditioners: filter FSM encoding,
// counter width and the DFP-to-filter-length decode.
package timers_pkg;

    localparam int CNT_W = 9;

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'b00,
        CHECK_HIGH  = 2'b01,
        STABLE_HIGH = 2'b11,
        CHECK_LOW   = 2'b10
    } pht_state_t;

    // Filter length L = 2^(DFP+1); widened before the +1 so DFP=7 yields 256.
    function automatic logic [CNT_W-1:0] dfp_to_len(input logic [2:0] dfp);
        logic [CNT_W-1:0] one;
        one = {{(CNT_W-1){1'b0}}, 1'b1};
        return one << ({1'b0, dfp} + 4'd1);
    endfunction

endpackage

// File: rtl/timers_sync_ff.sv
// Multi-stage metastability synchroniser with async active-low reset; shared by
// the PHT, INT0 and INT1 pin conditioners.
module timers_sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], d};
        end
    end

    assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/timers_pht_filter.sv
// PHT pin conditioner: synchroniser, TCON2 digital noise filter and TR2-gated
// active-edge pulse for Timer 2. Glitch counter built with TIMERS_PHT_GLITCH_CNT_EN.
module timers_pht_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 9
) (
    input  logic       timers_pht_filter_clock_i,
    input  logic       timers_pht_filter_reset_i,
    input  logic       timers_pht_filter_machine_cycle_i,
    input  logic       timers_pht_filter_pht_i,
    input  logic [2:0] timers_pht_filter_sfr_tcon2_dfp_i,
    input  logic       timers_pht_filter_sfr_tcon2_dfsel_i,
    input  logic       timers_pht_filter_sfr_tcon2_edsel_i,
    input  logic       timers_pht_filter_sfr_tcon2_tr2_i,
    output logic       timers_pht_filter_pht_level_o,
    output logic       timers_pht_filter_pht_edge_o,
    output logic [7:0] timers_pht_filter_glitch_cnt_o
);

    import timers_pkg::*;

    logic             clk;
    logic             rst_n;
    logic             s;
    logic             mc_d_reg;
    logic             tick;
    logic             dfsel;
    pht_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] len;
    logic             level_reg, level_next;
    logic             edge_reg, edge_next;

    assign clk   = timers_pht_filter_clock_i;
    assign rst_n = timers_pht_filter_reset_i;
    assign dfsel = timers_pht_filter_sfr_tcon2_dfsel_i;

    timers_sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (timers_pht_filter_pht_i),
        .q     (s)
    );

    assign tick    = timers_pht_filter_machine_cycle_i & ~mc_d_reg;
    assign len     = CNT_W'(dfp_to_len(timers_pht_filter_sfr_tcon2_dfp_i));
    assign cnt_inc = cnt_reg + CNT_W'(1);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        level_next = level_reg;
        if (!dfsel) begin
            // Bypass keeps the FSM parked on the current level so re-enabling is seamless.
            level_next = s;
            state_next = s ? STABLE_HIGH : STABLE_LOW;
            cnt_next   = '0;
        end else if (tick) begin
            case (state_reg)
                STABLE_LOW: begin
                    if (s) begin
                        state_next = CHECK_HIGH;
                        cnt_next   = CNT_W'(1);
                    end
                end
                CHECK_HIGH: begin
                    if (!s) begin
                        state_next = STABLE_LOW;
                        cnt_next   = '0;
                    end else if (cnt_inc >= len) begin
                        state_next = STABLE_HIGH;
                        level_next = 1'b1;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_inc;
                    end
                end
                STABLE_HIGH: begin
                    if (!s) begin
                        state_next = CHECK_LOW;
                        cnt_next   = CNT_W'(1);
                    end
                end
                CHECK_LOW: begin
                    if (s) begin
                        state_next = STABLE_HIGH;
                        cnt_next   = '0;
                    end else if (cnt_inc >= len) begin
                        state_next = STABLE_LOW;
                        level_next = 1'b0;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_inc;
                    end
                end
                default: begin
                    state_next = STABLE_LOW;
                    cnt_next   = '0;
                end
            endcase
        end
        // Pulse only on an actual level change, so an EDSEL write alone never fires.
        edge_next = (level_next != level_reg) &&
                    (level_next == timers_pht_filter_sfr_tcon2_edsel_i) &&
                    timers_pht_filter_sfr_tcon2_tr2_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mc_d_reg  <= 1'b0;
            state_reg <= STABLE_LOW;
            cnt_reg   <= '0;
            level_reg <= 1'b0;
            edge_reg  <= 1'b0;
        end else begin
            mc_d_reg  <= timers_pht_filter_machine_cycle_i;
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            level_reg <= level_next;
            edge_reg  <= edge_next;
        end
    end

    assign timers_pht_filter_pht_level_o = level_reg;
    assign timers_pht_filter_pht_edge_o  = edge_reg;

`ifdef TIMERS_PHT_GLITCH_CNT_EN
    logic       glitch_evt;
    logic [7:0] glitch_cnt_reg;

    assign glitch_evt = dfsel & tick &
                        (((state_reg == CHECK_HIGH) & ~s) | ((state_reg == CHECK_LOW) & s));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            glitch_cnt_reg <= 8'h00;
        end else if (glitch_evt && (glitch_cnt_reg != 8'hFF)) begin
            glitch_cnt_reg <= glitch_cnt_reg + 8'd1;
        end
    end

    assign timers_pht_filter_glitch_cnt_o = glitch_cnt_reg;
`else
    assign timers_pht_filter_glitch_cnt_o = 8'h00;
`endif

endmodule

// File: tb/tb_timers_pht_filter.sv
// Self-checking bench for timers_pht_filter: directed scenarios plus random
// stimulus, every clock compared against a run-length reference model.
module tb_timers_pht_filter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mc = 1'b0;
    logic       pin = 1'b0;
    logic [2:0] dfp = 3'd0;
    logic       dfsel = 1'b0;
    logic       edsel = 1'b1;
    logic       tr2 = 1'b1;
    logic       level_o;
    logic       edge_o;
    logic [7:0] gcnt_o;

    int n_vec = 0;
    int n_err = 0;
    int n_edges = 0;

    // Reference model state: pin delay line, previous strobe, level, run length.
    bit m_h0, m_h1, m_mcd, m_level, m_edge;
    int m_run, m_gcnt;

    always #5 clk = ~clk;

    timers_pht_filter #(
        .SYNC_STAGES (2),
        .CNT_W       (9)
    ) dut (
        .timers_pht_filter_clock_i           (clk),
        .timers_pht_filter_reset_i           (rst_n),
        .timers_pht_filter_machine_cycle_i   (mc),
        .timers_pht_filter_pht_i             (pin),
        .timers_pht_filter_sfr_tcon2_dfp_i   (dfp),
        .timers_pht_filter_sfr_tcon2_dfsel_i (dfsel),
        .timers_pht_filter_sfr_tcon2_edsel_i (edsel),
        .timers_pht_filter_sfr_tcon2_tr2_i   (tr2),
        .timers_pht_filter_pht_level_o       (level_o),
        .timers_pht_filter_pht_edge_o        (edge_o),
        .timers_pht_filter_glitch_cnt_o      (gcnt_o)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_gcnt();
`ifdef TIMERS_PHT_GLITCH_CNT_EN
        return m_gcnt;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        m_h0 = 0; m_h1 = 0; m_mcd = 0; m_level = 0; m_edge = 0;
        m_run = 0; m_gcnt = 0;
    endtask

    // Behaviour at one rising clock edge, using the inputs held across it.
    task automatic model_edge();
        bit s, tk, old;
        int len;
        if (!rst_n) begin
            model_reset();
            return;
        end
        s  = m_h1;
        tk = mc && !m_mcd;
        m_h1 = m_h0;
        m_h0 = pin;
        m_mcd = mc;
        len = 1 << (int'(dfp) + 1);
        old = m_level;
        if (!dfsel) begin
            m_level = s;
            m_run = 0;
        end else if (tk) begin
            if (s != m_level) begin
                m_run++;
                if (m_run >= len) begin
                    m_level = s;
                    m_run = 0;
                end
            end else begin
                if (m_run > 0 && m_gcnt < 255) m_gcnt++;
                m_run = 0;
            end
        end
        m_edge = (m_level != old) && (m_level == edsel) && tr2;
    endtask

    task automatic clk_step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        if (edge_o) n_edges++;
        chk("level", 16'(level_o), 16'(m_level));
        chk("edge", 16'(edge_o), 16'(m_edge));
        chk("glitch_cnt", 16'(gcnt_o), 16'(exp_gcnt()));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            mc = 1'b1;
            clk_step();
            mc = 1'b0;
            clk_step();
        end
    endtask

    initial begin
        int lat;
        model_reset();

        // Reset state
        repeat (3) clk_step();
        rst_n = 1'b1;
        clk_step();
        $display("phase reset: level=%0d edge=%0d gcnt=%0d", level_o, edge_o, gcnt_o);

        // Bypass: rising pin gives an edge exactly three clocks later
        dfsel = 1'b0; edsel = 1'b1; tr2 = 1'b1;
        repeat (3) clk_step();
        pin = 1'b1;
        lat = 0;
        for (int i = 1; i <= 10 && lat == 0; i++) begin
            clk_step();
            if (edge_o) lat = i;
        end
        chk("bypass_latency", 16'(lat), 16'd3);
        repeat (4) clk_step();
        pin = 1'b0;
        n_edges = 0;
        repeat (6) clk_step();
        chk("bypass_fall_no_edge", 16'(n_edges), 16'd0);
        $display("phase bypass: latency=%0d", lat);

        // Filter pass, falling edge active, L=4
        dfsel = 1'b1; dfp = 3'b001; edsel = 1'b0;
        pin = 1'b1;
        ticks(6);
        chk("filter_high", 16'(level_o), 16'd1);
        pin = 1'b0;
        n_edges = 0;
        ticks(6);
        chk("filter_low", 16'(level_o), 16'd0);
        chk("filter_fall_edges", 16'(n_edges), 16'd1);
        $display("phase filter: edges=%0d", n_edges);

        // Glitch reject, L=8, repeated until the counter saturates
        dfp = 3'b010; edsel = 1'b1;
        n_edges = 0;
        for (int g = 0; g < 300; g++) begin
            pin = 1'b1;
            ticks(5);
            pin = 1'b0;
            ticks(2);
        end
        chk("glitch_level", 16'(level_o), 16'd0);
        chk("glitch_edges", 16'(n_edges), 16'd0);
`ifdef TIMERS_PHT_GLITCH_CNT_EN
        chk("glitch_sat", 16'(gcnt_o), 16'd255);
`else
        chk("glitch_tied", 16'(gcnt_o), 16'd0);
`endif
        $display("phase glitch: gcnt=%0d", gcnt_o);

        // TR2 gating: transition while stopped is lost
        dfp = 3'b000; tr2 = 1'b0; edsel = 1'b1;
        n_edges = 0;
        pin = 1'b1;
        ticks(4);
        tr2 = 1'b1;
        ticks(3);
        chk("tr2_level", 16'(level_o), 16'd1);
        chk("tr2_edges", 16'(n_edges), 16'd0);
        $display("phase tr2: level=%0d edges=%0d", level_o, n_edges);

        // DFP shortened mid-check
        pin = 1'b0;
        ticks(4);
        dfp = 3'b111;
        pin = 1'b1;
        ticks(10);
        chk("dfp_hold", 16'(level_o), 16'd0);
        dfp = 3'b000;
        n_edges = 0;
        ticks(1);
        chk("dfp_shrink_level", 16'(level_o), 16'd1);
        chk("dfp_shrink_edge", 16'(n_edges), 16'd1);
        $display("phase dfp change: level=%0d", level_o);

        // Reset mid-check with pin high
        pin = 1'b0;
        ticks(4);
        dfp = 3'b010;
        pin = 1'b1;
        ticks(3);
        rst_n = 1'b0;
        #1;
        chk("rst_level", 16'(level_o), 16'd0);
        chk("rst_edge", 16'(edge_o), 16'd0);
        chk("rst_gcnt", 16'(gcnt_o), 16'd0);
        model_reset();
        repeat (2) clk_step();
        rst_n = 1'b1;
        n_edges = 0;
        ticks(10);
        chk("rst_rise_edge", 16'(n_edges), 16'd1);
        $display("phase reset mid-check: level=%0d", level_o);

        // Randomized stimulus
        for (int i = 0; i < 3000; i++) begin
            mc = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) pin = ~pin;
            if ($urandom_range(0, 299) == 0) dfsel = ~dfsel;
            if ($urandom_range(0, 99) == 0) dfp = 3'($urandom_range(0, 2));
            if ($urandom_range(0, 49) == 0) edsel = ~edsel;
            if ($urandom_range(0, 79) == 0) tr2 = ~tr2;
            clk_step();
        end
        $display("phase random: gcnt=%0d", gcnt_o);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
